if_fetch_unit: RTL and testbench

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/if_fetch_unit_pkg.sv | 6 +
 rtl/fetch_skid_buf.sv | 30 +++
 rtl/if_fetch_unit.sv | 129 ++++++++++++
 tb/tb_if_fetch_unit.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared FSM state type and PC constants for the fetch unit
package if_fetch_unit_pkg;
    typedef enum logic [1:0] {FETCH, SKID, DISCARD} fetch_state_e;
    localparam int PC_STEP = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry instruction+address holding buffer with valid and clear
module fetch_skid_buf #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [ADDR_W-1:0] addr_o
);
    // clear wins over load so a flushed entry can never be revived in the same cycle
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
            addr_o  <= '0;
        end else if (clear_i) begin
            valid_o <= 1'b0;
        end else if (load_i) begin
            valid_o <= 1'b1;
            data_o  <= data_i;
            addr_o  <= addr_i;
        end
    end
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch with one-entry skid, stall hold and redirect flush
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [DATA_W-1:0] imem_data_i,
    output logic              if_valid_o,
    output logic [DATA_W-1:0] if_instr_o,
    output logic [ADDR_W-1:0] if_pc_o,
    output logic [ADDR_W-1:0] if_pc_plus4_o
);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    fetch_state_e      state, state_n;
    logic [ADDR_W-1:0] req_addr, req_addr_n, pending_pc, pending_n;
    logic [ADDR_W-1:0] pc_n, plus4_n, redir_pc, pc_inc, skid_addr;
    logic [DATA_W-1:0] instr_n, skid_data;
    logic              valid_n, skid_load, skid_clear, skid_valid, slot_free;

    assign redir_pc    = redirect_pc_i & ~ADDR_W'(3);
    assign pc_inc      = req_addr + STEP;
    assign slot_free   = !if_valid_o || !stall_i;
    assign imem_req_o  = (state != SKID);
    assign imem_addr_o = req_addr;

    fetch_skid_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_skid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .data_i  (imem_data_i),
        .addr_i  (req_addr),
        .valid_o (skid_valid),
        .data_o  (skid_data),
        .addr_o  (skid_addr)
    );

    // state, request address and IF/ID register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state         <= FETCH;
            req_addr      <= RESET_PC;
            pending_pc    <= '0;
            if_valid_o    <= 1'b0;
            if_instr_o    <= '0;
            if_pc_o       <= '0;
            if_pc_plus4_o <= '0;
        end else begin
            state         <= state_n;
            req_addr      <= req_addr_n;
            pending_pc    <= pending_n;
            if_valid_o    <= valid_n;
            if_instr_o    <= instr_n;
            if_pc_o       <= pc_n;
            if_pc_plus4_o <= plus4_n;
        end
    end

    // next state; a consumed (unstalled) slot empties unless refilled, a redirect always empties it
    always_comb begin
        state_n    = state;
        req_addr_n = req_addr;
        pending_n  = pending_pc;
        valid_n    = (if_valid_o && stall_i) && !redirect_i;
        instr_n    = if_instr_o;
        pc_n       = if_pc_o;
        plus4_n    = if_pc_plus4_o;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        case (state)
            FETCH: begin
                if (redirect_i) begin
                    if (imem_ack_i) begin
                        req_addr_n = redir_pc;
                    end else begin
                        pending_n = redir_pc;
                        state_n   = DISCARD;
                    end
                end else if (imem_ack_i) begin
                    if (slot_free) begin
                        valid_n    = 1'b1;
                        instr_n    = imem_data_i;
                        pc_n       = req_addr;
                        plus4_n    = pc_inc;
                        req_addr_n = pc_inc;
                    end else begin
                        skid_load = 1'b1;
                        state_n   = SKID;
                    end
                end
            end
            SKID: begin
                if (redirect_i) begin
                    skid_clear = 1'b1;
                    req_addr_n = redir_pc;
                    state_n    = FETCH;
                end else if (!stall_i && skid_valid) begin
                    valid_n    = 1'b1;
                    instr_n    = skid_data;
                    pc_n       = skid_addr;
                    plus4_n    = skid_addr + STEP;
                    skid_clear = 1'b1;
                    req_addr_n = pc_inc;
                    state_n    = FETCH;
                end
            end
            DISCARD: begin
                if (imem_ack_i) begin
                    req_addr_n = redirect_i ? redir_pc : pending_pc;
                    state_n    = FETCH;
                end else if (redirect_i) begin
                    pending_n = redir_pc;
                end
            end
            default: state_n = FETCH;
        endcase
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: table-driven directed check of the fetch unit plus reset corner cases
module tb_if_fetch_unit;
    localparam logic [31:0] K = 32'h1357_9BDF;

    typedef struct {
        logic        s, r, a;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] epc;
        logic        er;
        logic [31:0] ea;
    } vec_t;

    logic        clk = 1'b0, rst = 1'b0, stall = 1'b0, redir = 1'b0, ack = 1'b0;
    logic [31:0] redir_pc = '0, imem_addr, imem_data, instr, pc, plus4;
    logic        imem_req, valid;
    int          checks = 0, errors = 0;
    vec_t        vecs [27];

    assign imem_data = imem_addr ^ K;

    if_fetch_unit dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .stall_i       (stall),
        .redirect_i    (redir),
        .redirect_pc_i (redir_pc),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_ack_i    (ack),
        .imem_data_i   (imem_data),
        .if_valid_o    (valid),
        .if_instr_o    (instr),
        .if_pc_o       (pc),
        .if_pc_plus4_o (plus4)
    );

    always #5 clk = ~clk;

    // the memory model never acknowledges without an outstanding request
    always @(posedge clk) begin
        if (rst) assert (!(ack && !imem_req)) else $error("protocol: ack with no request");
    end

    function automatic vec_t mk(logic s, logic r, logic a, logic [31:0] rpc,
                                logic ev, logic [31:0] epc, logic er, logic [31:0] ea);
        vec_t t;
        t.s = s; t.r = r; t.a = a; t.rpc = rpc;
        t.ev = ev; t.epc = epc; t.er = er; t.ea = ea;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            @(negedge clk);
            stall = vecs[i].s; redir = vecs[i].r; ack = vecs[i].a; redir_pc = vecs[i].rpc;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d valid", i), {31'b0, valid}, {31'b0, vecs[i].ev});
            chk($sformatf("v%0d req", i), {31'b0, imem_req}, {31'b0, vecs[i].er});
            chk($sformatf("v%0d addr", i), imem_addr, vecs[i].ea);
            if (vecs[i].ev) begin
                chk($sformatf("v%0d pc", i), pc, vecs[i].epc);
                chk($sformatf("v%0d pc4", i), plus4, vecs[i].epc + 32'd4);
                chk($sformatf("v%0d instr", i), instr, vecs[i].epc ^ K);
            end
        end
        @(negedge clk);
        stall = 1'b0; redir = 1'b0; ack = 1'b0; redir_pc = '0;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, " valid"}, {31'b0, valid}, 32'd0);
        chk({tag, " pc"}, pc, 32'd0);
        chk({tag, " pc4"}, plus4, 32'd0);
        chk({tag, " instr"}, instr, 32'd0);
        chk({tag, " req"}, {31'b0, imem_req}, 32'd1);
        chk({tag, " addr"}, imem_addr, 32'd0);
    endtask

    initial begin
        vecs[0]  = mk(0, 0, 1, 32'h0,        1, 32'h0,        1, 32'h4);
        vecs[1]  = mk(0, 0, 1, 32'h0,        1, 32'h4,        1, 32'h8);
        vecs[2]  = mk(0, 0, 1, 32'h0,        1, 32'h8,        1, 32'hC);
        vecs[3]  = mk(0, 0, 1, 32'h0,        1, 32'h0,        1, 32'h4);
        vecs[4]  = mk(0, 0, 1, 32'h0,        1, 32'h4,        1, 32'h8);
        vecs[5]  = mk(1, 0, 1, 32'h0,        1, 32'h4,        0, 32'h8);
        vecs[6]  = mk(1, 0, 0, 32'h0,        1, 32'h4,        0, 32'h8);
        vecs[7]  = mk(1, 0, 0, 32'h0,        1, 32'h4,        0, 32'h8);
        vecs[8]  = mk(0, 0, 0, 32'h0,        1, 32'h8,        1, 32'hC);
        vecs[9]  = mk(0, 1, 0, 32'h40,       0, 32'h0,        1, 32'hC);
        vecs[10] = mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'hC);
        vecs[11] = mk(0, 0, 1, 32'h0,        0, 32'h0,        1, 32'h40);
        vecs[12] = mk(0, 0, 1, 32'h0,        1, 32'h40,       1, 32'h44);
        vecs[13] = mk(1, 1, 1, 32'h80,       0, 32'h0,        1, 32'h80);
        vecs[14] = mk(0, 0, 1, 32'h0,        1, 32'h80,       1, 32'h84);
        vecs[15] = mk(0, 1, 1, 32'hFFFFFFFE, 0, 32'h0,        1, 32'hFFFFFFFC);
        vecs[16] = mk(0, 0, 1, 32'h0,        1, 32'hFFFFFFFC, 1, 32'h0);
        vecs[17] = mk(0, 0, 1, 32'h0,        1, 32'h0,        1, 32'h4);
        vecs[18] = mk(1, 0, 0, 32'h0,        1, 32'h0,        1, 32'h4);
        vecs[19] = mk(1, 0, 1, 32'h0,        1, 32'h0,        0, 32'h4);
        vecs[20] = mk(1, 1, 0, 32'h23,       0, 32'h0,        1, 32'h20);
        vecs[21] = mk(0, 0, 1, 32'h0,        1, 32'h20,       1, 32'h24);
        vecs[22] = mk(0, 1, 0, 32'h100,      0, 32'h0,        1, 32'h24);
        vecs[23] = mk(0, 1, 0, 32'h200,      0, 32'h0,        1, 32'h24);
        vecs[24] = mk(0, 0, 1, 32'h0,        0, 32'h0,        1, 32'h200);
        vecs[25] = mk(0, 1, 0, 32'h300,      0, 32'h0,        1, 32'h200);
        vecs[26] = mk(0, 0, 1, 32'h0,        1, 32'h0,        1, 32'h4);

        repeat (2) @(negedge clk);
        #1;
        chk_cleared("reset");
        rst = 1'b1;
        run(0, 2);

        rst = 1'b0;
        #1;
        chk_cleared("reset2");
        @(negedge clk);
        rst = 1'b1;
        run(3, 25);

        #2;
        rst = 1'b0;
        #1;
        chk_cleared("mid_discard_reset");
        @(negedge clk);
        rst = 1'b1;
        run(26, 26);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
